// File: rtl/render_pkg.sv
// Shared constants, colour-pack widths and FSM state type for the render frame controller.
package render_pkg;

    localparam int RFC_START_X       = 340;
    localparam int RFC_START_Y       = 390;
    localparam int RFC_END_X         = 684;
    localparam int RFC_END_Y         = 765;
    localparam int RFC_REGION_DIVIDE = 530;
    localparam int RFC_CYL_SHIFT     = 2;

    localparam int RGB_IN_W    = 24;
    localparam int RGB_OUT_W   = 12;
    localparam int HCOUNT_W    = 11;
    localparam int VCOUNT_W    = 10;
    localparam int ADDR_W      = 17;
    localparam int ADDR_CALC_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        RENDER,
        WAIT_SWAP
    } rfc_state_t;

    // RGB888 -> RGB444 by keeping the top nibble of each channel.
    function automatic logic [RGB_OUT_W-1:0] pack_rgb444(input logic [RGB_IN_W-1:0] rgb);
        return {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

endpackage

// File: rtl/render_fb_addr.sv
// Combinational window test and framebuffer address for one pixel coordinate.
module render_fb_addr
    import render_pkg::*;
#(
    parameter int START_X       = RFC_START_X,
    parameter int START_Y       = RFC_START_Y,
    parameter int END_X         = RFC_END_X,
    parameter int END_Y         = RFC_END_Y,
    parameter int REGION_DIVIDE = RFC_REGION_DIVIDE,
    parameter int CYL_SHIFT     = RFC_CYL_SHIFT
) (
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    output logic                write_ok,
    output logic [ADDR_W-1:0]   addr
);

    localparam logic [ADDR_CALC_W-1:0] SX    = ADDR_CALC_W'(START_X);
    localparam logic [ADDR_CALC_W-1:0] SY    = ADDR_CALC_W'(START_Y);
    localparam logic [ADDR_CALC_W-1:0] EX    = ADDR_CALC_W'(END_X);
    localparam logic [ADDR_CALC_W-1:0] EY    = ADDR_CALC_W'(END_Y);
    localparam logic [ADDR_CALC_W-1:0] RDIV  = ADDR_CALC_W'(REGION_DIVIDE);
    localparam logic [ADDR_CALC_W-1:0] SHIFT = ADDR_CALC_W'(CYL_SHIFT);
    localparam logic [ADDR_CALC_W-1:0] WIDTH = ADDR_CALC_W'(END_X - START_X);

    logic [ADDR_CALC_W-1:0]        h_ext;
    logic [ADDR_CALC_W-1:0]        v_ext;
    logic [ADDR_CALC_W-1:0]        shift;
    logic [ADDR_CALC_W-1:0]        h_off;
    logic [ADDR_CALC_W-1:0]        v_off;
    logic [ADDR_CALC_W-1:0]        addr_full;
    logic [ADDR_CALC_W-ADDR_W-1:0] addr_unused;
    logic                          in_window;

    assign h_ext = ADDR_CALC_W'(hcount);
    assign v_ext = ADDR_CALC_W'(vcount);

    // Rows above the region divide come from the cylinder and sit CYL_SHIFT columns right.
    assign shift = (v_ext < RDIV) ? SHIFT : '0;

    assign in_window = (h_ext >= SX) && (h_ext < EX) && (v_ext >= SY) && (v_ext < EY);
    assign h_off     = h_ext - SX;
    assign v_off     = v_ext - SY;
    assign write_ok  = in_window && (h_off >= shift);

    assign addr_full   = (h_off - shift) + v_off * WIDTH;
    assign addr        = addr_full[ADDR_W-1:0];
    assign addr_unused = addr_full[ADDR_CALC_W-1:ADDR_W];

endmodule

// File: rtl/render_frame_ctrl.sv
// Double-buffered framebuffer write controller: accepts rendered pixels, packs and
// addresses them, and swaps banks only between complete frames.
module render_frame_ctrl
    import render_pkg::*;
#(
    parameter int START_X       = RFC_START_X,
    parameter int START_Y       = RFC_START_Y,
    parameter int END_X         = RFC_END_X,
    parameter int END_Y         = RFC_END_Y,
    parameter int REGION_DIVIDE = RFC_REGION_DIVIDE,
    parameter int CYL_SHIFT     = RFC_CYL_SHIFT
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [RGB_IN_W-1:0]  pixel_axis_tdata,
    input  logic                 pixel_axis_tvalid,
    output logic                 pixel_axis_tready,
    input  logic [HCOUNT_W-1:0]  hcount_in,
    input  logic [VCOUNT_W-1:0]  vcount_in,
    input  logic                 nf_in,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [RGB_OUT_W-1:0] wr_data,
    output logic                 wr_bank,
    output logic                 rd_bank,
    output logic                 render_start,
    output logic                 frame_done,
    output logic [7:0]           overrun_count
);

    rfc_state_t        state;
    rfc_state_t        next_state;
    logic              swap;
    logic              start_req;
    logic              overrun_inc;
    logic              accept_p0;
    logic              write_ok_p0;
    logic              vld_p0;
    logic              last_pix_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [11:0]       tdata_unused;

    render_fb_addr #(
        .START_X       (START_X),
        .START_Y       (START_Y),
        .END_X         (END_X),
        .END_Y         (END_Y),
        .REGION_DIVIDE (REGION_DIVIDE),
        .CYL_SHIFT     (CYL_SHIFT)
    ) u_fb_addr (
        .hcount   (hcount_in),
        .vcount   (vcount_in),
        .write_ok (write_ok_p0),
        .addr     (addr_p0)
    );

    assign pixel_axis_tready = (state == RENDER);
    assign accept_p0         = pixel_axis_tvalid && pixel_axis_tready;
    assign vld_p0            = accept_p0 && write_ok_p0;
    assign last_pix_p0       = accept_p0
                               && (hcount_in == HCOUNT_W'(END_X - 1))
                               && (vcount_in == VCOUNT_W'(END_Y - 1));
    assign rd_bank           = ~wr_bank;
    assign tdata_unused      = {pixel_axis_tdata[19:16], pixel_axis_tdata[11:8],
                                pixel_axis_tdata[3:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A last pixel and nf_in in the same cycle closes the frame; the swap waits for the next nf_in.
    always_comb begin
        next_state  = state;
        swap        = 1'b0;
        start_req   = 1'b0;
        overrun_inc = 1'b0;
        case (state)
            IDLE: begin
                if (nf_in) begin
                    next_state = RENDER;
                    start_req  = 1'b1;
                end
            end
            RENDER: begin
                if (last_pix_p0) begin
                    next_state = WAIT_SWAP;
                end else if (nf_in) begin
                    overrun_inc = 1'b1;
                end
            end
            WAIT_SWAP: begin
                if (nf_in) begin
                    next_state = RENDER;
                    swap       = 1'b1;
                    start_req  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage p0 -> p1: registered write port, pulses, bank flag and overrun counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            render_start  <= 1'b0;
            frame_done    <= 1'b0;
            wr_bank       <= 1'b0;
            overrun_count <= '0;
        end else begin
            wr_en        <= vld_p0;
            render_start <= start_req;
            frame_done   <= last_pix_p0;
            if (vld_p0) begin
                wr_addr <= addr_p0;
                wr_data <= pack_rgb444(pixel_axis_tdata);
            end
            if (swap) begin
                wr_bank <= ~wr_bank;
            end
            if (overrun_inc && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

endmodule
